// File: rtl/div_if.sv
// rtl/div_if.sv - EX-stage to divider handshake bundle
//
// Groups the request/operand and result signals that pass between the EX
// stage (master) and the multi-cycle divider (slave).
//
// Signals (direction as seen by the divider):
//   signed_div_i  in   1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     in   32-bit dividend; sampled with start_i
//   opdata2_i     in   32-bit divisor; sampled with start_i
//   start_i       in   request, held high until the result is consumed
//   annul_i       in   cancel the current or pending operation
//   result_o      out  {remainder, quotient}, registered
//   ready_o       out  result valid, registered
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div.sv
// rtl/div.sv - 32-bit multi-cycle restoring divider for the EX stage
//
// Sequences 32 trial-subtraction iterations on the magnitudes of the
// operands, then fixes up the signs and presents {remainder, quotient}.
// A zero divisor short-circuits to a zero result after one extra cycle.
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset
//   bus   div_if.slave  operands/request in, result/ready out
module div (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  localparam logic [5:0] ITERATIONS = 6'd32;

  logic [1:0]  state_q,      state_d;
  logic [5:0]  cnt_q,        cnt_d;
  logic [64:0] dividend_q,   dividend_d;
  logic [31:0] divisor_q,    divisor_d;
  logic        signed_div_q, signed_div_d;
  logic        sign1_q,      sign1_d;
  logic        sign2_q,      sign2_d;
  logic [63:0] result_q,     result_d;
  logic        ready_q,      ready_d;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes; only meaningful in the cycle start_i is accepted.
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[31]) ?
                   (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[31]) ?
                   (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  // Trial subtraction of the divisor from the partial remainder; bit 32
  // set means the divisor did not fit and the quotient bit is 0.
  assign diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

  // Sign fixup: quotient negative when operand signs differ, remainder
  // takes the sign of the dividend. The remainder sits one bit up because
  // the work register was pre-shifted by one on load.
  assign quot_fix = (signed_div_q && (sign1_q ^ sign2_q)) ?
                    (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
  assign rem_fix  = (signed_div_q && sign1_q) ?
                    (~dividend_q[64:33] + 32'd1) : dividend_q[64:33];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    signed_div_d = signed_div_q;
    sign1_d      = sign1_q;
    sign2_d      = sign2_q;
    result_d     = result_q;
    ready_d      = ready_q;

    case (state_q)
      S_FREE: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          signed_div_d = bus.signed_div_i;
          sign1_d      = bus.opdata1_i[31];
          sign2_d      = bus.opdata2_i[31];
          if (bus.opdata2_i == 32'h0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = 6'd0;
            dividend_d = {32'h0, op1_abs, 1'b0};
            divisor_d  = op2_abs;
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_END;
        result_d = 64'h0;
        ready_d  = 1'b1;
      end

      S_ON: begin
        if (bus.annul_i) begin
          state_d  = S_FREE;
          cnt_d    = 6'd0;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else if (cnt_q != ITERATIONS) begin
          if (diff[32]) begin
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          cnt_d    = 6'd0;
          state_d  = S_END;
        end
      end

      S_END: begin
        // annul_i is deliberately not looked at: the result already exists.
        if (!bus.start_i) begin
          state_d  = S_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = S_FREE;
        result_d = 64'h0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FREE;
      cnt_q        <= 6'd0;
      dividend_q   <= 65'h0;
      divisor_q    <= 32'h0;
      signed_div_q <= 1'b0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      result_q     <= 64'h0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      signed_div_q <= signed_div_d;
      sign1_q      <= sign1_d;
      sign2_q      <= sign2_d;
      result_q     <= result_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
